// File: rtl/window_gen_pkg.sv
// Shared constants, window type and sizing helper for the 3x3 window generator.
// Optional feature macro used by this block: WINDOW_GEN_FRAME_DONE_EN.
package window_gen_pkg;

    localparam int WIN_ROWS = 3;
    localparam int WIN_COLS = 3;

    localparam int DEFAULT_ELEMENT_WIDTH = 32;

    // Window of default-width pixels, [row][col], row 0 = top line, col 0 = leftmost.
    typedef logic [DEFAULT_ELEMENT_WIDTH-1:0] window_t [WIN_ROWS][WIN_COLS];

    // Counter width for a modulo-n counter, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/window_gen_3x3_if.sv
// Pixel-in / window-out bundle of the 3x3 window generator.
// frame_done exists only when WINDOW_GEN_FRAME_DONE_EN is defined.
interface window_gen_3x3_if
    import window_gen_pkg::*;
#(
    parameter int ELEMENT_WIDTH = 32
);

    logic                     t;
    logic [ELEMENT_WIDTH-1:0] pixel_in;
    logic [ELEMENT_WIDTH-1:0] win_data [WIN_ROWS][WIN_COLS];
    logic                     t_out;
`ifdef WINDOW_GEN_FRAME_DONE_EN
    logic                     frame_done;

    modport master (
        output t, pixel_in,
        input  win_data, t_out, frame_done
    );

    modport slave (
        input  t, pixel_in,
        output win_data, t_out, frame_done
    );
`else
    modport master (
        output t, pixel_in,
        input  win_data, t_out
    );

    modport slave (
        input  t, pixel_in,
        output win_data, t_out
    );
`endif

endinterface

// File: rtl/window_gen_3x3_line_buffer_rw.sv
// Single-port line buffer: read and write at the same index in the same cycle,
// the read returns the value stored before this cycle's write.
module line_buffer_rw
    import window_gen_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int IDX_W      = cnt_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [IDX_W-1:0]      idx,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // NOTE: the array is deliberately left without a reset; a reset port on a
    // memory blocks RAM inference and stale lines are masked by the row counter.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wr_data;
        end
    end

    assign rd_data = mem[idx];

endmodule

// File: rtl/window_gen_3x3.sv
// Streaming 3x3 sliding-window generator over a raster pixel stream.
// Define WINDOW_GEN_FRAME_DONE_EN to add the one-cycle frame_done pulse.
module window_gen_3x3
    import window_gen_pkg::*;
#(
    parameter int ELEMENT_WIDTH = 32,
    parameter int IMG_WIDTH     = 16,
    parameter int IMG_HEIGHT    = 16
) (
    input  logic             clk,
    input  logic             rst,
    window_gen_3x3_if.slave  bus
);

    localparam int COL_W = cnt_width(IMG_WIDTH);
    localparam int ROW_W = cnt_width(IMG_HEIGHT);

    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_FIRST = COL_W'(WIN_COLS - 1);
    localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(WIN_ROWS - 1);

    logic [COL_W-1:0]         col;
    logic [ROW_W-1:0]         row;
    logic [ELEMENT_WIDTH-1:0] lb0_rd;
    logic [ELEMENT_WIDTH-1:0] lb1_rd;
    logic [ELEMENT_WIDTH-1:0] win_q [WIN_ROWS][WIN_COLS];
    logic                     t_out_q;
    logic                     window_ready;
    logic                     col_wrap;
    logic                     row_wrap;

    // A window is complete once two full lines and two pixels of this line are in.
    assign window_ready = (row >= ROW_FIRST) && (col >= COL_FIRST);
    assign col_wrap     = (col == COL_LAST);
    assign row_wrap     = (row == ROW_LAST);

    // LB1 holds the previous line; its old entry moves into LB0 (two lines back).
    line_buffer_rw #(
        .DATA_WIDTH (ELEMENT_WIDTH),
        .DEPTH      (IMG_WIDTH)
    ) u_lb0 (
        .clk     (clk),
        .we      (bus.t),
        .idx     (col),
        .wr_data (lb1_rd),
        .rd_data (lb0_rd)
    );

    line_buffer_rw #(
        .DATA_WIDTH (ELEMENT_WIDTH),
        .DEPTH      (IMG_WIDTH)
    ) u_lb1 (
        .clk     (clk),
        .we      (bus.t),
        .idx     (col),
        .wr_data (bus.pixel_in),
        .rd_data (lb1_rd)
    );

    // NOTE: every register here uses <= so all reads in this block see the
    // pre-edge values; the left shift of the window depends on that.
    always_ff @(posedge clk) begin
        if (rst) begin
            col     <= '0;
            row     <= '0;
            t_out_q <= 1'b0;
            for (int r = 0; r < WIN_ROWS; r++) begin
                for (int c = 0; c < WIN_COLS; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else begin
            t_out_q <= bus.t && window_ready;
            if (bus.t) begin
                for (int r = 0; r < WIN_ROWS; r++) begin
                    for (int c = 0; c < WIN_COLS - 1; c++) begin
                        win_q[r][c] <= win_q[r][c+1];
                    end
                end
                win_q[0][WIN_COLS-1] <= lb0_rd;
                win_q[1][WIN_COLS-1] <= lb1_rd;
                win_q[2][WIN_COLS-1] <= bus.pixel_in;

                if (col_wrap) begin
                    col <= '0;
                    row <= row_wrap ? '0 : row + ROW_W'(1);
                end else begin
                    col <= col + COL_W'(1);
                end
            end
        end
    end

    assign bus.t_out    = t_out_q;
    assign bus.win_data = win_q;

`ifdef WINDOW_GEN_FRAME_DONE_EN
    logic frame_done_q;

    // Coincides with t_out of the bottom-right window, the last of the frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= bus.t && col_wrap && row_wrap;
        end
    end

    assign bus.frame_done = frame_done_q;
`endif

endmodule

// File: tb/tb_window_gen_3x3.sv
// Self-checking bench for window_gen_3x3 on a 4x4 image: table vectors, corner
// sequences and a randomized run against a frame-array reference model.
module tb_window_gen_3x3;
    import window_gen_pkg::*;

    localparam int EW = 32;
    localparam int IW = 4;
    localparam int IH = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    window_gen_3x3_if #(.ELEMENT_WIDTH(EW)) bus ();

    window_gen_3x3 #(
        .ELEMENT_WIDTH (EW),
        .IMG_WIDTH     (IW),
        .IMG_HEIGHT    (IH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        t;
        logic [31:0] pix;
        logic        exp_t_out;
        window_t     exp_win;
    } vec_t;

    int checks   = 0;
    int failures = 0;
    int pulses   = 0;
    int m_pulses = 0;
    int fd_pulses = 0;
    int m_fd_pulses = 0;

    // Reference model: the frame so far as a 2-D array plus the raster position.
    logic [31:0] img [IH][IW];
    int          m_row;
    int          m_col;
    logic        m_t_out;
    logic        m_fd;

    vec_t basic [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_win(input string name, input window_t exp);
        for (int i = 0; i < WIN_ROWS; i++) begin
            for (int j = 0; j < WIN_COLS; j++) begin
                check($sformatf("%s[%0d][%0d]", name, i, j), bus.win_data[i][j], exp[i][j]);
            end
        end
    endtask

    // One clock: drive inputs, let the edge pass, then compare against the model.
    task automatic drive(input logic tv, input logic [31:0] pix);
        bus.t        = tv;
        bus.pixel_in = pix;
        @(posedge clk);
        #1;
        m_t_out = 1'b0;
        m_fd    = 1'b0;
        if (tv) begin
            img[m_row][m_col] = pix;
            if (m_row >= 2 && m_col >= 2) begin
                m_t_out = 1'b1;
                m_pulses++;
            end
            if (m_row == IH - 1 && m_col == IW - 1) begin
                m_fd = 1'b1;
                m_fd_pulses++;
            end
            check("t_out", bus.t_out, m_t_out);
            if (m_t_out) begin
                for (int i = 0; i < 3; i++) begin
                    for (int j = 0; j < 3; j++) begin
                        check($sformatf("model_win[%0d][%0d]", i, j), bus.win_data[i][j],
                              img[m_row - 2 + i][m_col - 2 + j]);
                    end
                end
            end
            m_col++;
            if (m_col == IW) begin
                m_col = 0;
                m_row = (m_row == IH - 1) ? 0 : m_row + 1;
            end
        end else begin
            check("t_out_stall", bus.t_out, 1'b0);
        end
        if (bus.t_out === 1'b1) pulses++;
`ifdef WINDOW_GEN_FRAME_DONE_EN
        check("frame_done", bus.frame_done, m_fd);
        if (bus.frame_done === 1'b1) fd_pulses++;
`endif
    endtask

    task automatic do_reset();
        bus.t        = 1'b0;
        bus.pixel_in = '0;
        rst          = 1'b1;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        m_row = 0;
        m_col = 0;
        check("reset_t_out", bus.t_out, 1'b0);
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                check($sformatf("reset_win[%0d][%0d]", i, j), bus.win_data[i][j], 32'd0);
            end
        end
`ifdef WINDOW_GEN_FRAME_DONE_EN
        check("reset_frame_done", bus.frame_done, 1'b0);
`endif
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst          = 1'b1;
        bus.t        = 1'b0;
        bus.pixel_in = '0;
        repeat (2) @(posedge clk);
        #1;

        // Basic 4x4 frame, pixel = row*4+col, continuous t; includes the line wrap.
        for (int i = 0; i < 16; i++) begin
            basic[i].t         = 1'b1;
            basic[i].pix       = i;
            basic[i].exp_t_out = 1'b0;
            basic[i].exp_win   = '{default: '0};
        end
        basic[10].exp_t_out = 1'b1;
        basic[10].exp_win   = '{'{0, 1, 2}, '{4, 5, 6}, '{8, 9, 10}};
        basic[11].exp_t_out = 1'b1;
        basic[11].exp_win   = '{'{1, 2, 3}, '{5, 6, 7}, '{9, 10, 11}};
        basic[14].exp_t_out = 1'b1;
        basic[14].exp_win   = '{'{4, 5, 6}, '{8, 9, 10}, '{12, 13, 14}};
        basic[15].exp_t_out = 1'b1;
        basic[15].exp_win   = '{'{5, 6, 7}, '{9, 10, 11}, '{13, 14, 15}};

        do_reset();
        pulses = 0;
        for (int i = 0; i < 16; i++) begin
            drive(basic[i].t, basic[i].pix);
            check($sformatf("tbl_t_out_%0d", i), bus.t_out, basic[i].exp_t_out);
            if (basic[i].exp_t_out) check_win($sformatf("tbl_win_%0d", i), basic[i].exp_win);
        end
        check("basic_pulses", pulses, 4);

        // Stall of three cycles between pixels 9 and 10.
        do_reset();
        pulses = 0;
        for (int i = 0; i < 10; i++) drive(1'b1, i);
        repeat (3) drive(1'b0, 32'hdead_beef);
        check("stall_no_pulse", pulses, 0);
        drive(1'b1, 10);
        check("stall_first_t_out", bus.t_out, 1'b1);
        check_win("stall_win", '{'{0, 1, 2}, '{4, 5, 6}, '{8, 9, 10}});
        for (int i = 11; i < 16; i++) drive(1'b1, i);
        check("stall_pulses", pulses, 4);

        // Two back-to-back frames, second frame pixels = 100 + index.
        do_reset();
        pulses    = 0;
        fd_pulses = 0;
        for (int i = 0; i < 16; i++) drive(1'b1, i);
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 100 + i);
            if (i == 10) begin
                check("b2b_first_t_out", bus.t_out, 1'b1);
                check_win("b2b_win", '{'{100, 101, 102}, '{104, 105, 106}, '{108, 109, 110}});
            end
        end
        check("b2b_pulses", pulses, 8);
`ifdef WINDOW_GEN_FRAME_DONE_EN
        check("b2b_frame_done_pulses", fd_pulses, 2);
`endif

        // Mid-frame reset after pixel 11, then a fresh frame of 200 + index.
        do_reset();
        for (int i = 0; i < 12; i++) drive(1'b1, i);
        do_reset();
        pulses = 0;
        for (int i = 0; i < 10; i++) drive(1'b1, 200 + i);
        check("midrst_no_early_pulse", pulses, 0);
        drive(1'b1, 210);
        check("midrst_first_t_out", bus.t_out, 1'b1);
        check_win("midrst_win", '{'{200, 201, 202}, '{204, 205, 206}, '{208, 209, 210}});
        for (int i = 11; i < 16; i++) drive(1'b1, 200 + i);
        check("midrst_pulses", pulses, 4);

        // Randomized stream with stalls and occasional resets.
        do_reset();
        pulses      = 0;
        m_pulses    = 0;
        fd_pulses   = 0;
        m_fd_pulses = 0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                drive($urandom_range(0, 9) < 7, $urandom);
            end
        end
        check("rand_pulses", pulses, m_pulses);
`ifdef WINDOW_GEN_FRAME_DONE_EN
        check("rand_frame_done_pulses", fd_pulses, m_fd_pulses);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/window_gen_3x3.md
Name: window_gen_3x3

Overview:
- Streaming 3x3 sliding-window generator. Sits directly upstream of the 3x3 weighted-average stencil op.
- Accepts one raster-order pixel per cycle when t is high.
- Buffers the two previous image lines.
- Presents a full 3x3 neighbourhood plus a time-valid pulse (t_out), which drives the consumer's t and i_rd_data directly.

Parameters:
- ELEMENT_WIDTH, 32: pixel bit width.
- IMG_WIDTH, 16: pixels per line; must be ≥ 3.
- IMG_HEIGHT, 16: lines per frame; must be ≥ 3.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous active-high reset.
- t  input  1  pixel-valid strobe; pixel_in accepted in every cycle t=1.
- pixel_in  input  ELEMENT_WIDTH  raster-order pixel.
- win_data  output  ELEMENT_WIDTH x [2:0][2:0] (unpacked)  window; [r][c], r=0 oldest line (top), c=0 oldest column (left).
- t_out  output  1  window-valid pulse, aligned with win_data.

Behaviour:
- Reset, synchronous on rst=1 at posedge:
  - col=0, row=0.
  - t_out=0; all win_data=0.
  - Line-buffer contents are not cleared. They are don't-care because no window is emitted before row 2 is refilled.
- Reset mid-frame: the partial frame is discarded; the next accepted pixel is treated as (row 0, col 0).
- Storage:
  - Two line buffers, LB1 (previous line) and LB0 (line before), each IMG_WIDTH deep, indexed by col.
  - A 3x3 window register array.
- On a cycle with t=1, in parallel:
  - The window shifts left: column c ← c+1 for each row.
  - New column 2: win[0][2]=LB0[col], win[1][2]=LB1[col], win[2][2]=pixel_in.
  - LB0[col] ← LB1[col]; LB1[col] ← pixel_in.
  - col increments. At col=IMG_WIDTH-1, col→0 and row increments.
  - At row=IMG_HEIGHT-1, col=IMG_WIDTH-1, both wrap to 0 (next frame starts; line buffers keep stale data, masked by the row counter).
- t_out:
  - Registered; asserts one cycle after the accepting cycle.
  - Asserts iff that accepting cycle had row ≥ 2 and col ≥ 2 (pre-increment values).
  - Latency pixel_in→t_out/win_data = 1 cycle.
- On a cycle with t=0:
  - No counters, buffers or window registers change.
  - t_out deasserts the following cycle.
  - Stalls of any length are allowed.
- Window count: exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2) t_out pulses per frame. No border windows.
- Line wrap: columns 0 and 1 of each row refill the window. No t_out for them, so left-edge data never mixes with the previous line's right edge.
- win_data holds its last value while t_out=0. It is only guaranteed meaningful when t_out=1.
- Counter widths: $clog2(IMG_WIDTH), $clog2(IMG_HEIGHT), minimum 1 bit.
- No arithmetic on pixel data.

Optional Feature:
- Macro: WINDOW_GEN_FRAME_DONE_EN.
- Defined:
  - Adds output port frame_done (1 bit), reset 0.
  - Pulses high for exactly one cycle, coincident with the t_out of the last window of a frame (pixel row IMG_HEIGHT-1, col IMG_WIDTH-1).
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package window_gen_pkg:
  - Localparams WIN_ROWS=3, WIN_COLS=3.
  - Typedef for a window array of ELEMENT_WIDTH pixels.
- One natural sub-module: line_buffer_rw, a single-port, IMG_WIDTH-deep buffer that reads and writes at the same index in the same cycle (read-before-write, old value returned). It is instantiated twice.
- Counters and window registers stay in the top module.

Test Plan:
- Basic window, IMG_WIDTH=4, IMG_HEIGHT=4, pixel=row*4+col, t=1 continuously from reset release:
  - First t_out one cycle after pixel 10, with win = {{0,1,2},{4,5,6},{8,9,10}}.
  - Then t_out with win = {{1,2,3},{5,6,7},{9,10,11}}.
  - Exactly 4 pulses total, last window ending at pixel 15.
- Stall, same stream with t=0 for 3 cycles between pixels 9 and 10:
  - Identical window values; t_out delayed by 3 cycles; no t_out during stall.
- Line wrap, same 4x4 stream: no t_out after pixels 12 and 13; the next pulse follows pixel 14 with win = {{4,5,6},{8,9,10},{12,13,14}}.
- Back-to-back frames, two 4x4 frames with frame 2 pixels = 100+index:
  - Exactly 8 t_out total.
  - First frame-2 window = {{100,101,102},{104,105,106},{108,109,110}}, with no frame-1 data.
- Mid-frame reset: rst=1 for 1 cycle after pixel 11, then a fresh frame:
  - t_out=0 and win_data=0 on the cycle after reset.
  - The first window appears only after the new frame's pixel 10.
- WINDOW_GEN_FRAME_DONE_EN defined, 4x4: frame_done pulses once per frame, in the same cycle as the 4th t_out; never otherwise.
